led_scan_capture: RTL and testbench
===================================

// Module: led_scan_capture
// PURPOSE
//  Receive-side counterpart of LEDDriver: observes the row-scanned LED board bus
//  (row select + red/green column drives) and rebuilds full 16x16 RedPixels/GrnPixels frames.
//  Used as on-chip loopback monitor and self-check target in the DE1_SoC LED-board path.
//  Delivers a frame only after a complete, in-order row 0..ROWS-1 sweep.
// PARAMETERS
//  ROWS    16  rows per frame (row index width = $clog2(ROWS))
//  COLS    16  columns per row
//  SETTLE  4   cycles a row must be held stable with ScanValid=1 before sampling (>=1)
// PORTS
//  CLK        in   1          system clock (CLOCK_50 domain)
//  RST        in   1          synchronous reset, active-high
//  ScanRow    in   4          row index currently driven
//  ScanRed    in   COLS       red column data for ScanRow
//  ScanGrn    in   COLS       green column data for ScanRow
//  ScanValid  in   1          1 = row drive active (0 during blanking)
//  RedFrame   out  ROWS*COLS  last complete red frame, [row][col]
//  GrnFrame   out  ROWS*COLS  last complete green frame, [row][col]
//  FrameValid out  1          one-cycle pulse: RedFrame/GrnFrame just updated
//  FrameCount out  8          completed frames, wraps 255->0
//  SeqErr     out  1          one-cycle pulse: out-of-order row detected
// BEHAVIOUR
//  Reset: RedFrame=GrnFrame=0, FrameValid=0, SeqErr=0, FrameCount=0, shadow buffer cleared,
//   settle counter=0, state=HUNT, expected row=0. Reset mid-frame discards partial shadow.
//  Dwell tracking: ScanRow/ScanValid registered; a change of ScanRow, or ScanValid=0, clears
//   settle counter and the per-dwell captured flag. Counter saturates at SETTLE-1.
//  Capture event: ScanValid=1, row unchanged, counter==SETTLE-1, captured flag clear ->
//   sample {ScanRow,ScanRed,ScanGrn} once; set captured flag. Long dwells capture once only.
//   Capture occurs SETTLE cycles after the row change edge is registered.
//  FSM (2 states):
//   HUNT: capture of row 0 -> write shadow[0], expected=1, go LOCK. Other rows ignored, no SeqErr.
//   LOCK: capture row==expected -> write shadow[row]; expected++.
//     row==ROWS-1 -> next cycle: RedFrame/GrnFrame <= shadow (incl. this row),
//       FrameValid=1, FrameCount++ (mod 256), expected=0, stay LOCK.
//     row!=expected -> SeqErr=1 next cycle, shadow discarded;
//       captured row==0 -> write shadow[0], expected=1, stay LOCK; else go HUNT.
//  Output frame changes only on FrameValid cycle; otherwise holds (double-buffered).
//  Simultaneous frame completion and reset: reset wins.
//  ScanRow >= ROWS: treated as out-of-order in LOCK, ignored in HUNT.
//  FrameValid and SeqErr never asserted in the same cycle.
// CONFIGURATION
//  SCAN_SYNC_EN defined: ScanRow/ScanRed/ScanGrn/ScanValid pass through 2-FF synchronizers
//   (reset to 0) before dwell tracking; all latencies +2 cycles. For pins from external board.
//  Not defined: inputs used directly (same-clock loopback from LEDDriver); latencies as above.
// TESTING
//  1 Reset, then rows 0..15 each held 8 cycles, Red[r]=16'h0001<<r, Grn=~Red -> one FrameValid
//    pulse, RedFrame = identity diagonal, GrnFrame complement, FrameCount=1, SeqErr never.
//  2 Start scan at row 5..15 then 0..15 -> no SeqErr in HUNT, exactly one FrameValid after row 15.
//  3 In LOCK send rows 0,1,2,4 -> SeqErr pulse at row-4 capture, no FrameValid, FrameRegs unchanged;
//    then clean 0..15 -> FrameValid, FrameCount increments by 1.
//  4 Row held SETTLE-1=3 cycles only, or ScanValid dropped at cycle 2 -> no capture; hold 40
//    cycles -> single capture (no duplicate, no SeqErr).
//  5 256 clean frames -> FrameCount wraps to 0, FrameValid pulses = 256.
//  6 Assert RST after row 9 of a frame -> all outputs 0 next cycle; rows 10..15 give no FrameValid.

Source files
------------

// File: rtl/led_scan_capture.sv
// led_scan_capture
//   Receive-side monitor for the row-scanned LED board bus. Watches the row
//   select and red/green column drives, samples each row once it has been
//   held stable long enough, and rebuilds complete ROWS x COLS frames. A frame
//   is only published after an unbroken, in-order sweep of rows 0..ROWS-1.
//
// Parameters
//   ROWS    rows per frame (row index width = $clog2(ROWS))
//   COLS    columns per row
//   SETTLE  stable cycles (with ScanValid=1) before a row is sampled, >= 1
//
// Ports
//   CLK         system clock
//   RST         synchronous reset, active-high
//   ScanRow     row index currently driven
//   ScanRed     red column data for ScanRow
//   ScanGrn     green column data for ScanRow
//   ScanValid   1 = row drive active, 0 = blanking
//   RedFrame    last complete red frame, bit [row*COLS+col]
//   GrnFrame    last complete green frame, bit [row*COLS+col]
//   FrameValid  one-cycle pulse, RedFrame/GrnFrame just updated
//   FrameCount  completed frames, wraps 255 -> 0
//   SeqErr      one-cycle pulse, out-of-order row detected
//
// Configuration
//   SCAN_SYNC_EN  when defined, all Scan* inputs pass through 2-FF
//                 synchronizers before dwell tracking (+2 cycles latency).

module led_scan_capture #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int SETTLE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [$clog2(ROWS)-1:0] ScanRow,
  input  logic [COLS-1:0]         ScanRed,
  input  logic [COLS-1:0]         ScanGrn,
  input  logic                    ScanValid,
  output logic [ROWS*COLS-1:0]    RedFrame,
  output logic [ROWS*COLS-1:0]    GrnFrame,
  output logic                    FrameValid,
  output logic [7:0]              FrameCount,
  output logic                    SeqErr
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  logic [RW-1:0]   row_s;
  logic [COLS-1:0] red_s;
  logic [COLS-1:0] grn_s;
  logic            valid_s;

`ifdef SCAN_SYNC_EN
  logic [RW-1:0]   row_m;
  logic [COLS-1:0] red_m;
  logic [COLS-1:0] grn_m;
  logic            valid_m;

  // Board pins arrive asynchronously; two flops per bit before use.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_m   <= '0;
      red_m   <= '0;
      grn_m   <= '0;
      valid_m <= 1'b0;
      row_s   <= '0;
      red_s   <= '0;
      grn_s   <= '0;
      valid_s <= 1'b0;
    end else begin
      row_m   <= ScanRow;
      red_m   <= ScanRed;
      grn_m   <= ScanGrn;
      valid_m <= ScanValid;
      row_s   <= row_m;
      red_s   <= red_m;
      grn_s   <= grn_m;
      valid_s <= valid_m;
    end
  end
`else
  assign row_s   = ScanRow;
  assign red_s   = ScanRed;
  assign grn_s   = ScanGrn;
  assign valid_s = ScanValid;
`endif

  // Dwell tracking. A cycle is "stable" only if this and the previous cycle
  // were both driven with the same row, so blanking and row changes both
  // restart the settle count.
  logic [RW-1:0] row_q;
  logic          valid_q;
  logic [CW-1:0] settle_cnt;
  logic          captured;
  logic          stable;
  logic          cap_evt;

  assign stable  = valid_s && valid_q && (row_s == row_q);
  assign cap_evt = stable && (settle_cnt == CNT_MAX) && !captured;

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q      <= '0;
      valid_q    <= 1'b0;
      settle_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      row_q   <= row_s;
      valid_q <= valid_s;
      if (!stable) begin
        settle_cnt <= '0;
        captured   <= 1'b0;
      end else begin
        if (settle_cnt != CNT_MAX)
          settle_cnt <= settle_cnt + CW'(1);
        if (cap_evt)
          captured <= 1'b1;
      end
    end
  end

  // Sequencing FSM: state register.
  state_t        state, state_next;
  logic [RW-1:0] expected, expected_next;
  logic          shadow_clear;
  logic          shadow_write;
  logic          frame_load;
  logic          seq_err_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= HUNT;
      expected <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
    end
  end

  // Sequencing FSM: next state and datapath controls. Only a capture event
  // can move anything.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    shadow_clear  = 1'b0;
    shadow_write  = 1'b0;
    frame_load    = 1'b0;
    seq_err_next  = 1'b0;
    if (cap_evt) begin
      case (state)
        HUNT: begin
          if (row_s == '0) begin
            shadow_write  = 1'b1;
            expected_next = RW'(1);
            state_next    = LOCK;
          end
        end
        LOCK: begin
          if (row_s == expected) begin
            shadow_write = 1'b1;
            if (row_s == LAST_ROW) begin
              frame_load    = 1'b1;
              expected_next = '0;
            end else begin
              expected_next = expected + RW'(1);
            end
          end else begin
            // A row 0 that breaks the sequence is also a valid new start.
            seq_err_next = 1'b1;
            shadow_clear = 1'b1;
            if (row_s == '0) begin
              shadow_write  = 1'b1;
              expected_next = RW'(1);
            end else begin
              expected_next = '0;
              state_next    = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Shadow buffer collects the sweep in progress; the output frame is only
  // loaded on completion, merging in the last row straight from the bus.
  logic [COLS-1:0] shadow_red [ROWS];
  logic [COLS-1:0] shadow_grn [ROWS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < ROWS; r++) begin
        shadow_red[r] <= '0;
        shadow_grn[r] <= '0;
      end
      RedFrame   <= '0;
      GrnFrame   <= '0;
      FrameValid <= 1'b0;
      SeqErr     <= 1'b0;
      FrameCount <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (shadow_write && (row_s == RW'(r))) begin
          shadow_red[r] <= red_s;
          shadow_grn[r] <= grn_s;
        end else if (shadow_clear) begin
          shadow_red[r] <= '0;
          shadow_grn[r] <= '0;
        end
      end
      if (frame_load) begin
        for (int r = 0; r < ROWS; r++) begin
          RedFrame[r*COLS +: COLS] <= (row_s == RW'(r)) ? red_s : shadow_red[r];
          GrnFrame[r*COLS +: COLS] <= (row_s == RW'(r)) ? grn_s : shadow_grn[r];
        end
        FrameCount <= FrameCount + 8'd1;
      end
      FrameValid <= frame_load;
      SeqErr     <= seq_err_next;
    end
  end

endmodule

// File: tb/tb_led_scan_capture.sv
// tb_led_scan_capture
//   Drives dwells (row held for N cycles, optionally followed by a blanking
//   cycle) into led_scan_capture. A dwell-level reference model predicts each
//   FrameValid / SeqErr event and queues it; a monitor pops and compares
//   whenever the DUT raises either pulse.

module tb_led_scan_capture;

  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int SETTLE = 4;
  localparam int NB     = ROWS * COLS;

  logic            CLK = 1'b0;
  logic            RST;
  logic [3:0]      ScanRow;
  logic [COLS-1:0] ScanRed;
  logic [COLS-1:0] ScanGrn;
  logic            ScanValid;
  logic [NB-1:0]   RedFrame;
  logic [NB-1:0]   GrnFrame;
  logic            FrameValid;
  logic [7:0]      FrameCount;
  logic            SeqErr;

  led_scan_capture #(.ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RST(RST), .ScanRow(ScanRow), .ScanRed(ScanRed),
    .ScanGrn(ScanGrn), .ScanValid(ScanValid), .RedFrame(RedFrame),
    .GrnFrame(GrnFrame), .FrameValid(FrameValid), .FrameCount(FrameCount),
    .SeqErr(SeqErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_frame;
    logic [NB-1:0] red;
    logic [NB-1:0] grn;
    int          count;
  } event_t;

  event_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int frame_pulses = 0;

  // Reference model: a run of in-order captured rows since lock.
  bit              m_locked;
  logic [COLS-1:0] m_run_red[$];
  logic [COLS-1:0] m_run_grn[$];
  int              m_count;
  logic [NB-1:0]   m_last_red;
  logic [NB-1:0]   m_last_grn;

  int last_row   = 0;
  bit last_blank = 1'b1;

  task automatic check_num(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_locked = 1'b0;
    m_run_red.delete();
    m_run_grn.delete();
    m_count = 0;
    m_last_red = '0;
    m_last_grn = '0;
  endfunction

  function automatic void model_capture(input int r, input logic [COLS-1:0] red, input logic [COLS-1:0] grn);
    event_t e;
    if (!m_locked) begin
      if (r == 0) begin
        m_run_red = {red};
        m_run_grn = {grn};
        m_locked  = 1'b1;
      end
    end else if (r == m_run_red.size()) begin
      m_run_red.push_back(red);
      m_run_grn.push_back(grn);
      if (m_run_red.size() == ROWS) begin
        for (int i = 0; i < ROWS; i++) begin
          m_last_red[i*COLS +: COLS] = m_run_red[i];
          m_last_grn[i*COLS +: COLS] = m_run_grn[i];
        end
        m_count = (m_count + 1) % 256;
        m_run_red.delete();
        m_run_grn.delete();
        e.is_frame = 1'b1;
        e.red = m_last_red;
        e.grn = m_last_grn;
        e.count = m_count;
        exp_q.push_back(e);
      end
    end else begin
      e.is_frame = 1'b0;
      e.red = m_last_red;
      e.grn = m_last_grn;
      e.count = m_count;
      exp_q.push_back(e);
      m_run_red.delete();
      m_run_grn.delete();
      if (r == 0) begin
        m_run_red.push_back(red);
        m_run_grn.push_back(grn);
      end else begin
        m_locked = 1'b0;
      end
    end
  endfunction

  // One dwell: row held valid for len cycles, optionally followed by blanking.
  task automatic apply_stimulus(input int row, input logic [COLS-1:0] red,
                                input logic [COLS-1:0] grn, input int len, input bit blank);
    if (len > 0) begin
      if (row == last_row && !last_blank) begin
        @(negedge CLK);
        ScanValid = 1'b0;
      end
      if (len >= SETTLE + 1)
        model_capture(row, red, grn);
      for (int i = 0; i < len; i++) begin
        @(negedge CLK);
        ScanRow   = 4'(row);
        ScanRed   = red;
        ScanGrn   = grn;
        ScanValid = 1'b1;
      end
      last_row   = row;
      last_blank = 1'b0;
    end
    if (blank) begin
      @(negedge CLK);
      ScanValid  = 1'b0;
      last_blank = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    repeat (SETTLE + 4) begin
      @(negedge CLK);
      ScanValid = 1'b0;
    end
    last_blank = 1'b1;
    check_num(name, exp_q.size(), 0);
  endtask

  task automatic check_output(input string name);
    check_frame({name, "_red"}, RedFrame, m_last_red);
    check_frame({name, "_grn"}, GrnFrame, m_last_grn);
    check_num({name, "_count"}, int'(FrameCount), m_count);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    ScanValid = 1'b0;
    @(negedge CLK);
    model_reset();
    exp_q.delete();
    check_frame("rst_red", RedFrame, '0);
    check_frame("rst_grn", GrnFrame, '0);
    check_num("rst_count", int'(FrameCount), 0);
    check_num("rst_pulses", int'(FrameValid) + int'(SeqErr), 0);
    RST = 1'b0;
    last_blank = 1'b1;
  endtask

  task automatic clean_frame(input int len);
    logic [COLS-1:0] r_d, g_d;
    for (int r = 0; r < ROWS; r++) begin
      r_d = 16'($urandom);
      g_d = 16'($urandom);
      apply_stimulus(r, r_d, g_d, len, 1'b0);
    end
  endtask

  // Monitor: every DUT pulse must match the oldest predicted event.
  initial begin
    event_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST && (FrameValid || SeqErr)) begin
        if (FrameValid) frame_pulses++;
        check_num("pulse_exclusive", int'(FrameValid && SeqErr), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse: got FrameValid=%0d SeqErr=%0d expected none", FrameValid, SeqErr);
        end else begin
          e = exp_q.pop_front();
          check_num("event_kind", int'(FrameValid), int'(e.is_frame));
          check_frame("event_red", RedFrame, e.red);
          check_frame("event_grn", GrnFrame, e.grn);
          check_num("event_count", int'(FrameCount), e.count);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NB-1:0]   diag;
    logic [COLS-1:0] r_d, g_d;
    int p0, c0, row, len, sel;

    RST = 1'b0;
    ScanRow = '0;
    ScanRed = '0;
    ScanGrn = '0;
    ScanValid = 1'b0;
    model_reset();
    do_reset();

    // Diagonal frame.
    diag = '0;
    for (int r = 0; r < ROWS; r++) diag[r*COLS + r] = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      r_d = 16'h0001 << r;
      apply_stimulus(r, r_d, ~r_d, 8, 1'b0);
    end
    drain("t1_drain");
    check_frame("t1_red_diag", RedFrame, diag);
    check_frame("t1_grn_diag", GrnFrame, ~diag);
    check_num("t1_count", int'(FrameCount), 1);
    check_num("t1_pulses", frame_pulses, 1);

    // Start mid-scan while hunting.
    do_reset();
    p0 = frame_pulses;
    for (int r = 5; r < ROWS; r++) apply_stimulus(r, 16'($urandom), 16'($urandom), 6, 1'b1);
    clean_frame(6);
    drain("t2_drain");
    check_num("t2_pulses", frame_pulses - p0, 1);
    check_output("t2_out");

    // Skipped row while locked.
    c0 = m_count;
    for (int r = 0; r < 3; r++) apply_stimulus(r, 16'($urandom), 16'($urandom), 6, 1'b0);
    apply_stimulus(4, 16'($urandom), 16'($urandom), 6, 1'b0);
    drain("t3_drain_err");
    check_output("t3_hold");
    clean_frame(6);
    drain("t3_drain");
    check_num("t3_count_inc", int'(FrameCount), (c0 + 1) % 256);

    // Short dwells, dropped valid, long dwell.
    p0 = frame_pulses;
    for (int r = 0; r < 3; r++) apply_stimulus(r, 16'($urandom), 16'($urandom), 5, 1'b0);
    apply_stimulus(3, 16'h1111, 16'h2222, SETTLE - 1, 1'b1);
    apply_stimulus(3, 16'h3333, 16'h4444, 2, 1'b1);
    apply_stimulus(3, 16'h5555, 16'h6666, 40, 1'b0);
    for (int r = 4; r < ROWS; r++) apply_stimulus(r, 16'($urandom), 16'($urandom), 5, 1'b0);
    drain("t4_drain");
    check_num("t4_pulses", frame_pulses - p0, 1);
    check_frame("t4_row3", RedFrame & (NB'(16'hFFFF) << 48), NB'(16'h5555) << 48);

    // Randomized dwells around the settle boundary with injected disorder.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) row = $urandom_range(0, ROWS - 1);
      else row = m_locked ? m_run_red.size() : 0;
      sel = $urandom_range(0, 9);
      case (sel)
        0: len = SETTLE - 1;
        1: len = SETTLE;
        7: len = SETTLE + 2;
        8: len = 8;
        9: len = ($urandom_range(0, 3) == 0) ? 40 : 6;
        default: len = SETTLE + 1;
      endcase
      apply_stimulus(row, 16'($urandom), 16'($urandom), len, 1'($urandom_range(0, 1)));
    end
    drain("rand_drain");
    check_output("rand_out");

    // Frame counter wrap.
    do_reset();
    p0 = frame_pulses;
    for (int f = 0; f < 256; f++) clean_frame(SETTLE + 1);
    drain("t5_drain");
    check_num("t5_pulses", frame_pulses - p0, 256);
    check_num("t5_wrap", int'(FrameCount), 0);

    // Reset in the middle of a sweep.
    clean_frame(5);
    drain("t6_pre");
    for (int r = 0; r < 10; r++) apply_stimulus(r, 16'($urandom), 16'($urandom), 5, 1'b0);
    do_reset();
    p0 = frame_pulses;
    for (int r = 10; r < ROWS; r++) apply_stimulus(r, 16'($urandom), 16'($urandom), 5, 1'b0);
    drain("t6_drain");
    check_num("t6_pulses", frame_pulses - p0, 0);
    check_output("t6_out");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
